// File: rtl/layer5_result_flatten_reader_if.sv
// Output stream bundle from the layer-5 result reader to the layer-6 input
// stage: a registered valid/ready beat carrying one map word, its spatial
// index and an end-of-scan marker.
interface layer5_result_flatten_reader_if #(
  parameter int DATA_W = 128
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/layer5_result_flatten_reader.sv
// Read-side sequencer for the layer-5 result buffer (MAP_DIM x MAP_DIM words).
// A start pulse scans the whole map through the buffer's combinational read
// port and streams every word, with its row*MAP_DIM+col index, over a
// registered valid/ready port, then pulses done for one cycle.
// Scan order is raster (row-major) by default; defining the macro
// LAYER5_READER_COL_MAJOR_EN switches to column-major order. The final
// position and the reported index formula are identical in both orders.
// MAP_DIM must lie in 1..7: the buffer only decodes address bits [2:0].
module layer5_result_flatten_reader #(
  parameter int MAP_DIM = 5,
  parameter int DATA_W  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [15:0]           mem_read_row_addr,
  output logic [15:0]           mem_read_col_addr,
  output logic                  mem_read_signal,
  input  logic [DATA_W-1:0]     mem_data_in,
  layer5_result_flatten_reader_if.master stream,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_POS = 3'(MAP_DIM - 1);
  localparam logic [7:0] DIM8     = 8'(MAP_DIM);

  state_t state, state_nx;

  logic [2:0]        row_cnt;
  logic [2:0]        col_cnt;
  logic              at_final;
  logic              load;
  logic              accept;

  logic              vld_p0;
  logic              last_p0;
  logic [DATA_W-1:0] data_p0;
  logic [7:0]        index_p0;

  // Spatial index of a map position; independent of scan order.
  function automatic logic [7:0] index_of(input logic [2:0] r, input logic [2:0] c);
    return 8'(r) * DIM8 + 8'(c);
  endfunction

  assign at_final = (row_cnt == LAST_POS) && (col_cnt == LAST_POS);
  // A new word may enter the output register when it is empty or being drained
  // this cycle, which gives one beat per cycle while the consumer is ready.
  assign load     = (state == READ) && (!vld_p0 || stream.out_ready);
  assign accept   = vld_p0 && stream.out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start is honoured only from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (load && at_final) state_nx = DRAIN;
      DRAIN:   if (accept && last_p0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Buffer read port and status outputs; addresses come straight from the
  // registered counters so no input reaches them combinationally.
  always_comb begin
    mem_read_signal   = 1'b0;
    mem_read_row_addr = 16'd0;
    mem_read_col_addr = 16'd0;
    busy              = (state != IDLE);
    done              = (state == FIN);
    if (state == READ) begin
      mem_read_signal   = 1'b1;
      mem_read_row_addr = {13'd0, row_cnt};
      mem_read_col_addr = {13'd0, col_cnt};
    end
  end

  // Scan position counters: cleared on start, advanced on each load and
  // frozen while the output register is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= 3'd0;
      col_cnt <= 3'd0;
    end else if (state == IDLE && start) begin
      row_cnt <= 3'd0;
      col_cnt <= 3'd0;
    end else if (load) begin
`ifdef LAYER5_READER_COL_MAJOR_EN
      if (row_cnt == LAST_POS) begin
        row_cnt <= 3'd0;
        col_cnt <= (col_cnt == LAST_POS) ? 3'd0 : col_cnt + 3'd1;
      end else begin
        row_cnt <= row_cnt + 3'd1;
      end
`else
      if (col_cnt == LAST_POS) begin
        col_cnt <= 3'd0;
        row_cnt <= (row_cnt == LAST_POS) ? 3'd0 : row_cnt + 3'd1;
      end else begin
        col_cnt <= col_cnt + 3'd1;
      end
`endif
    end
  end

  // ---- stage p0: output register (buffer read data -> consumer) ----
  // Captures a word on load, holds it while stalled, and empties only when
  // the held beat is accepted with nothing new arriving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      data_p0  <= '0;
      index_p0 <= 8'd0;
    end else if (load) begin
      vld_p0   <= 1'b1;
      last_p0  <= at_final;
      data_p0  <= mem_data_in;
      index_p0 <= index_of(row_cnt, col_cnt);
    end else if (accept) begin
      vld_p0   <= 1'b0;
    end
  end

  assign stream.out_valid = vld_p0;
  assign stream.out_data  = data_p0;
  assign stream.out_index = index_p0;
  assign stream.out_last  = last_p0;

endmodule

// File: tb/tb_layer5_result_flatten_reader.sv
// Directed bench for layer5_result_flatten_reader (MAP_DIM=5, DATA_W=128).
// A behavioural buffer returns word(r,c) for the addressed position; every
// beat, address and status output is compared with positions derived from
// the beat number. Honours LAYER5_READER_COL_MAJOR_EN for the scan order.
module tb_layer5_result_flatten_reader;

  localparam int DATA_W = 128;
  localparam int DIM    = 5;
  localparam int NB     = DIM * DIM;
  localparam int BOUND  = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       mem_read_row_addr;
  logic [15:0]       mem_read_col_addr;
  logic              mem_read_signal;
  logic [DATA_W-1:0] mem_data_in;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  layer5_result_flatten_reader_if #(.DATA_W(DATA_W)) ob ();

  layer5_result_flatten_reader #(.MAP_DIM(DIM), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .mem_read_row_addr (mem_read_row_addr),
    .mem_read_col_addr (mem_read_col_addr),
    .mem_read_signal   (mem_read_signal),
    .mem_data_in       (mem_data_in),
    .stream            (ob.master),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input logic [15:0] r, input logic [15:0] c);
    return {r[7:0] ^ 8'hA5, 104'd0, r[7:0], c[7:0]};
  endfunction

  always_comb mem_data_in = mem_read_signal ? word(mem_read_row_addr, mem_read_col_addr) : '0;

  function automatic int pos_r(input int k);
`ifdef LAYER5_READER_COL_MAJOR_EN
    return k % DIM;
`else
    return k / DIM;
`endif
  endfunction

  function automatic int pos_c(input int k);
`ifdef LAYER5_READER_COL_MAJOR_EN
    return k / DIM;
`else
    return k % DIM;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string sfx);
    check({"rst_valid", sfx}, ob.out_valid, 0);
    check({"rst_data", sfx}, ob.out_data, 0);
    check({"rst_index", sfx}, ob.out_index, 0);
    check({"rst_last", sfx}, ob.out_last, 0);
    check({"rst_busy", sfx}, busy, 0);
    check({"rst_done", sfx}, done, 0);
    check({"rst_rd", sfx}, mem_read_signal, 0);
    check({"rst_row", sfx}, mem_read_row_addr, 0);
    check({"rst_col", sfx}, mem_read_col_addr, 0);
  endtask

  // One scan. do_start: pulse start first (else continue a scan already in
  // flight at beat 0). toggle: out_ready follows 1,0,0,1. extra: pulse start
  // at the 5th handshake and on the done cycle.
  task automatic run_scan(input bit do_start, input bit toggle, input bit extra);
    int k      = 0;
    int t      = 0;
    int t_last = -10;
    int dones  = 0;
    bit fin    = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      ob.out_ready = 1'b1;
    end
    while (!fin && t < BOUND) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_in_scan", busy, 1);
      if (done) begin
        dones++;
        fin = 1;
        check("done_latency", t, t_last + 1);
        check("done_valid", ob.out_valid, 0);
        if (extra) start = 1'b1;
      end else begin
        if (do_start && t == 0) check("first_cycle_valid", ob.out_valid, 0);
        else if (k < NB) check("no_bubble", ob.out_valid, 1);
        if (ob.out_valid && k < NB) begin
          check("index", ob.out_index, pos_r(k) * DIM + pos_c(k));
          check("data", ob.out_data, word(16'(pos_r(k)), 16'(pos_c(k))));
          check("last", ob.out_last, (k == NB - 1));
          if (k < NB - 1) begin
            check("rd_sig", mem_read_signal, 1);
            check("row_addr", mem_read_row_addr, pos_r(k + 1));
            check("col_addr", mem_read_col_addr, pos_c(k + 1));
          end else begin
            check("drain_rd_sig", mem_read_signal, 0);
            check("drain_row_addr", mem_read_row_addr, 0);
            check("drain_col_addr", mem_read_col_addr, 0);
          end
        end else if (k < NB) begin
          check("rd_sig_empty", mem_read_signal, 1);
          check("row_addr_empty", mem_read_row_addr, pos_r(k));
          check("col_addr_empty", mem_read_col_addr, pos_c(k));
        end
      end
      ob.out_ready = toggle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      if (ob.out_valid && ob.out_ready && k < NB) begin
        k++;
        if (k == NB) t_last = t;
        if (extra && k == 5) start = 1'b1;
      end
      t++;
    end
    check("done_seen", fin, 1);
    check("beat_count", k, NB);
    check("done_count", dones, 1);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", ob.out_valid, 0);
    check("idle_done", done, 0);
    @(negedge clk);
    check("idle_busy_2", busy, 0);
    check("idle_rd_sig", mem_read_signal, 0);
  endtask

  initial begin
    ob.out_ready = 1'b0;
    #1;
    check_all_zero("_init");
    @(negedge clk);
    rst = 1'b0;

    // Full scan with the consumer always ready.
    run_scan(1'b1, 1'b0, 1'b0);

    // Full scan with out_ready toggling 1,0,0,1.
    run_scan(1'b1, 1'b1, 1'b0);

    // First beat stalled for 10 cycles, then resumed.
    @(negedge clk);
    start = 1'b1;
    ob.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("stall_pre_valid", ob.out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", ob.out_valid, 1);
      check("stall_index", ob.out_index, 0);
      check("stall_data", ob.out_data, word(16'd0, 16'd0));
      check("stall_row_addr", mem_read_row_addr, pos_r(1));
      check("stall_col_addr", mem_read_col_addr, pos_c(1));
    end
    run_scan(1'b0, 1'b0, 1'b0);

    // Stray start pulses mid-scan and on the done cycle.
    run_scan(1'b1, 1'b0, 1'b1);

    // Reset in the middle of a scan, then a fresh scan.
    @(negedge clk);
    start = 1'b1;
    ob.out_ready = 1'b1;
    begin
      int w = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        w++;
      end while (!(ob.out_valid && ob.out_index == 8'd12) && w < 50);
      check("reach_beat12", ob.out_index, 12);
    end
    rst = 1'b1;
    #1;
    check_all_zero("_async");
    @(negedge clk);
    check_all_zero("_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_scan(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
